// File: rtl/lt24_panel_rx.sv
// lt24_panel_rx: panel-side responder for the LT24 (ILI9341-style) 8080 bus.
// Decodes commands and CASET/PASET windows, and turns RAMWR pixel streams into
// single-cycle writes on a single-port frame-buffer port.
// Optional feature macro: LT24_RAMRD_EN (enables the RAMRD 0x2E read path).
module lt24_panel_rx #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              mclk,
    input  logic              puc_rst_n,
    input  logic              lt24_cs_n_i,
    input  logic              lt24_rs_i,
    input  logic              lt24_wr_n_i,
    input  logic              lt24_rd_n_i,
    input  logic              lt24_reset_n_i,
    input  logic [15:0]       lt24_d_i,
    output logic [15:0]       lt24_d_o,
    output logic              lt24_d_oen_o,
    output logic              fb_cen_o,
    output logic              fb_wen_o,
    output logic [ADDR_W-1:0] fb_addr_o,
    output logic [15:0]       fb_din_o,
    input  logic [15:0]       fb_dout_i,
    output logic              disp_on_o,
    output logic              frame_done_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CASET = 3'd1,
        ST_PASET = 3'd2,
        ST_RAMWR = 3'd3,
        ST_RAMRD = 3'd4
    } state_t;

    localparam logic [15:0] H_RES_C  = 16'(H_RES);
    localparam logic [15:0] V_RES_C  = 16'(V_RES);
    localparam logic [15:0] H_LAST_C = 16'(H_RES - 1);
    localparam logic [15:0] V_LAST_C = 16'(V_RES - 1);

    state_t state_r, state_nxt_s;

    // bus strobe synchronisers (idle high) and previous-value flops for edges
    logic [1:0] cs_sync_r, wr_sync_r, rd_sync_r;
    logic       cs_prev_r, wr_prev_r, rd_prev_r;

    // window, position and parameter capture registers
    logic [15:0] sc_r, ec_r, sp_r, ep_r, col_r, page_r;
    logic [1:0]  k_r;
    logic [7:0]  prm_s_msb_r, prm_s_lsb_r, prm_e_msb_r;

    // output registers
    logic [15:0]       d_out_r;
    logic              oen_r, cen_r, wen_r, disp_on_r, frame_done_r;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       din_r;
    logic              rd_pend1_r, rd_pend2_r;

    // decoded events and datapath controls
    logic        wr_evt_s, cs_rise_s, rd_fall_s, rd_rise_s;
    logic        srst_s, sw_rst_s, disp_off_s, disp_on_s;
    logic        enter_win_s, load_pos_s, param_s, wr_issue_s, rd_issue_s;
    logic        advance_s, rd_end_s;
    logic [7:0]  cmd_s;
    logic [15:0] col_adv_s, page_adv_s, win_start_s, win_end_s;
    logic        wrap_s, in_range_s, win_ok_s;
    logic [31:0] addr_full_s;

    assign wr_evt_s  = wr_sync_r[1] & ~wr_prev_r & ~cs_sync_r[1];
    assign cs_rise_s = cs_sync_r[1] & ~cs_prev_r;
    assign rd_fall_s = ~rd_sync_r[1] & rd_prev_r & ~cs_sync_r[1];
    assign rd_rise_s = rd_sync_r[1] & ~rd_prev_r;
    assign cmd_s     = lt24_d_i[7:0];
    assign srst_s    = ~lt24_reset_n_i | sw_rst_s;

    assign addr_full_s = 32'(page_r) * 32'(H_RES) + 32'(col_r);
    assign in_range_s  = (col_r < H_RES_C) && (page_r < V_RES_C);
    assign win_start_s = {prm_s_msb_r, prm_s_lsb_r};
    assign win_end_s   = {prm_e_msb_r, lt24_d_i[7:0]};
    assign win_ok_s    = (win_start_s <= win_end_s);

    // next column/page after one pixel, wrapping inside the current window
    always_comb begin
        col_adv_s  = col_r;
        page_adv_s = page_r;
        wrap_s     = 1'b0;
        if (col_r == ec_r) begin
            col_adv_s = sc_r;
            if (page_r == ep_r) begin
                page_adv_s = sp_r;
                wrap_s     = 1'b1;
            end else begin
                page_adv_s = page_r + 16'd1;
            end
        end else begin
            col_adv_s = col_r + 16'd1;
        end
    end

    // next-state and event decode; a write event takes priority over reads
    always_comb begin
        state_nxt_s = state_r;
        sw_rst_s    = 1'b0;
        disp_off_s  = 1'b0;
        disp_on_s   = 1'b0;
        enter_win_s = 1'b0;
        load_pos_s  = 1'b0;
        param_s     = 1'b0;
        wr_issue_s  = 1'b0;
        rd_issue_s  = 1'b0;
        advance_s   = 1'b0;
        rd_end_s    = 1'b0;
        if (wr_evt_s) begin
            if (!lt24_rs_i) begin
                case (cmd_s)
                    8'h01: begin sw_rst_s = 1'b1; state_nxt_s = ST_IDLE; end
                    8'h28: begin disp_off_s = 1'b1; state_nxt_s = ST_IDLE; end
                    8'h29: begin disp_on_s = 1'b1; state_nxt_s = ST_IDLE; end
                    8'h2A: begin enter_win_s = 1'b1; state_nxt_s = ST_CASET; end
                    8'h2B: begin enter_win_s = 1'b1; state_nxt_s = ST_PASET; end
                    8'h2C: begin load_pos_s = 1'b1; state_nxt_s = ST_RAMWR; end
`ifdef LT24_RAMRD_EN
                    8'h2E: begin load_pos_s = 1'b1; state_nxt_s = ST_RAMRD; end
`endif
                    default: state_nxt_s = ST_IDLE;
                endcase
            end else begin
                case (state_r)
                    ST_CASET, ST_PASET: begin
                        param_s = 1'b1;
                        if (k_r == 2'd3) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end
                    ST_RAMWR: begin
                        wr_issue_s = 1'b1;
                        advance_s  = 1'b1;
                    end
                    default: state_nxt_s = state_r;
                endcase
            end
        end else if (rd_fall_s && (state_r == ST_RAMRD)) begin
            rd_issue_s = 1'b1;
        end else if (rd_rise_s && (state_r == ST_RAMRD)) begin
            advance_s = 1'b1;
            rd_end_s  = 1'b1;
        end else if (cs_rise_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // state register
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_r <= ST_IDLE;
        end else if (srst_s) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // strobe synchronisers and edge-detect history
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            cs_sync_r <= 2'b11; wr_sync_r <= 2'b11; rd_sync_r <= 2'b11;
            cs_prev_r <= 1'b1;  wr_prev_r <= 1'b1;  rd_prev_r <= 1'b1;
        end else if (srst_s) begin
            cs_sync_r <= 2'b11; wr_sync_r <= 2'b11; rd_sync_r <= 2'b11;
            cs_prev_r <= 1'b1;  wr_prev_r <= 1'b1;  rd_prev_r <= 1'b1;
        end else begin
            cs_sync_r <= {cs_sync_r[0], lt24_cs_n_i};
            wr_sync_r <= {wr_sync_r[0], lt24_wr_n_i};
            rd_sync_r <= {rd_sync_r[0], lt24_rd_n_i};
            cs_prev_r <= cs_sync_r[1];
            wr_prev_r <= wr_sync_r[1];
            rd_prev_r <= rd_sync_r[1];
        end
    end

    // window, pixel position, frame-buffer strobes and read-back path
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            sc_r <= 16'd0; ec_r <= H_LAST_C; sp_r <= 16'd0; ep_r <= V_LAST_C;
            col_r <= 16'd0; page_r <= 16'd0; k_r <= 2'd0;
            prm_s_msb_r <= 8'd0; prm_s_lsb_r <= 8'd0; prm_e_msb_r <= 8'd0;
            d_out_r <= 16'd0; oen_r <= 1'b1; cen_r <= 1'b1; wen_r <= 1'b1;
            addr_r <= '0; din_r <= 16'd0; disp_on_r <= 1'b0; frame_done_r <= 1'b0;
            rd_pend1_r <= 1'b0; rd_pend2_r <= 1'b0;
        end else if (srst_s) begin
            sc_r <= 16'd0; ec_r <= H_LAST_C; sp_r <= 16'd0; ep_r <= V_LAST_C;
            col_r <= 16'd0; page_r <= 16'd0; k_r <= 2'd0;
            prm_s_msb_r <= 8'd0; prm_s_lsb_r <= 8'd0; prm_e_msb_r <= 8'd0;
            d_out_r <= 16'd0; oen_r <= 1'b1; cen_r <= 1'b1; wen_r <= 1'b1;
            addr_r <= '0; din_r <= 16'd0; disp_on_r <= 1'b0; frame_done_r <= 1'b0;
            rd_pend1_r <= 1'b0; rd_pend2_r <= 1'b0;
        end else begin
            cen_r        <= 1'b1;
            wen_r        <= 1'b1;
            frame_done_r <= 1'b0;
            rd_pend1_r   <= rd_issue_s;
            rd_pend2_r   <= rd_pend1_r;

            if (disp_on_s) disp_on_r <= 1'b1;
            else if (disp_off_s) disp_on_r <= 1'b0;
            else disp_on_r <= disp_on_r;

            if (enter_win_s) k_r <= 2'd0;
            if (param_s) begin
                k_r <= k_r + 2'd1;
                case (k_r)
                    2'd0: prm_s_msb_r <= lt24_d_i[7:0];
                    2'd1: prm_s_lsb_r <= lt24_d_i[7:0];
                    2'd2: prm_e_msb_r <= lt24_d_i[7:0];
                    2'd3: begin
                        // commit start/end together, or keep the old window
                        if (win_ok_s && (state_r == ST_CASET)) begin
                            sc_r <= win_start_s;
                            ec_r <= win_end_s;
                        end else if (win_ok_s && (state_r == ST_PASET)) begin
                            sp_r <= win_start_s;
                            ep_r <= win_end_s;
                        end
                    end
                    default: k_r <= 2'd0;
                endcase
            end

            if (load_pos_s) begin
                col_r  <= sc_r;
                page_r <= sp_r;
            end else if (advance_s) begin
                col_r  <= col_adv_s;
                page_r <= page_adv_s;
            end

            if (wr_issue_s) begin
                addr_r <= addr_full_s[ADDR_W-1:0];
                din_r  <= lt24_d_i;
                if (in_range_s) begin
                    cen_r        <= 1'b0;
                    wen_r        <= 1'b0;
                    frame_done_r <= wrap_s;
                end
            end

            if (rd_issue_s) begin
                addr_r <= addr_full_s[ADDR_W-1:0];
                if (in_range_s) cen_r <= 1'b0;
            end

            // RAM data arrives one cycle after the read strobe
            if (rd_pend2_r && (state_r == ST_RAMRD)) begin
                d_out_r <= fb_dout_i;
                oen_r   <= 1'b0;
            end
            if (rd_end_s || (state_nxt_s != ST_RAMRD)) oen_r <= 1'b1;
        end
    end

    assign lt24_d_o     = d_out_r;
    assign lt24_d_oen_o = oen_r;
    assign fb_cen_o     = cen_r;
    assign fb_wen_o     = wen_r;
    assign fb_addr_o    = addr_r;
    assign fb_din_o     = din_r;
    assign disp_on_o    = disp_on_r;
    assign frame_done_o = frame_done_r;

endmodule
